// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx
//   UART receiver driven by a 16x (OVERSAMPLE x) baud enable. It synchronises
//   the asynchronous serial line, detects a start edge, samples every bit at
//   its mid-point, shifts data in LSB first and checks the stop bit. Each
//   finished frame produces a one-clock rx_valid_o strobe. The strobe is
//   issued even when the frame has an error.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   : a parity bit follows the data bits and is checked against
//                 PARITY_ODD (0 = even, 1 = odd).
//     undefined : there is no parity bit, and parity_err_o is tied to 0.
//
// Parameters
//   DATA_WIDTH   data bits per frame (5..9)
//   OVERSAMPLE   baud_en_i ticks per bit (even, >= 4)
//   SYNC_STAGES  flops in the rx_i synchroniser (>= 2)
//   PARITY_ODD   parity sense when parity is enabled
//
// Ports
//   clk_i         clock
//   rst_i         asynchronous reset, active-high
//   baud_en_i     one-cycle tick at OVERSAMPLE x baud rate
//   rx_i          serial line, idle high, asynchronous to clk_i
//   rx_data_o     last received word, held until the next frame completes
//   rx_valid_o    one-cycle strobe: rx_data_o and error flags were updated
//   frame_err_o   stop bit was sampled as 0
//   parity_err_o  parity mismatch (0 when parity is disabled)
//   busy_o        receiver is inside a frame (any state but IDLE)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  baud_en_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  frame_err_o,
  output logic                  parity_err_o,
  output logic                  busy_o
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  // Invalid configurations are rejected at elaboration.
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_rx: DATA_WIDTH must be 5..9");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("uart_rx: SYNC_STAGES must be >= 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_s;        // synchronised line
  logic                    rx_q;        // line value at the previous tick
  logic [TICK_W-1:0]       tick_cnt_q;
  logic [BIT_W-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-1:0]   shift_q;

  // The synchroniser resets to 1, which is the idle line level. It runs on
  // every clock, independent of baud_en_i.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesised registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign busy_o = (state_q != S_IDLE);

`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_SENSE = (PARITY_ODD != 0);
  logic par_bit_q;
  logic parity_err_q;
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      // rx_q starts at 0, so a line that is already low after reset is not
      // taken as a start edge before it has been seen high.
      rx_q         <= 1'b0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_o <= 1'b0;
      if (baud_en_i) begin
        // rx_q follows the line on every tick in every state. On returning to
        // IDLE it therefore holds the last bit sampled. After a break (stop
        // bit = 0) a new start needs the line to go high and then low again.
        rx_q <= rx_s;
        case (state_q)
          S_IDLE: begin
            if (rx_q && !rx_s) begin
              state_q    <= S_START;
              tick_cnt_q <= '0;
            end
          end
          S_START: begin
            if (tick_cnt_q == TICK_MID) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              // A start bit that is no longer low at its mid-point is a
              // glitch. The receiver drops it silently.
              state_q    <= rx_s ? S_IDLE : S_DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          S_DATA: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              shift_q    <= {rx_s, shift_q[DATA_WIDTH-1:1]};
              if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              par_bit_q  <= rx_s;
              state_q    <= S_STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`endif
          S_STOP: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q   <= '0;
              rx_data_o    <= shift_q;
              frame_err_o  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= ((^shift_q) ^ par_bit_q) != PARITY_SENSE;
`endif
              rx_valid_o   <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
